// File: rtl/xeng_win_sched_pkg.sv
// Shared types and helpers for the X-engine window scheduler.
package xeng_win_sched_pkg;

    // Scheduler states; IDLE must stay at the all-zero encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SYNC = 2'd2,
        ST_RUN  = 2'd3
    } sched_state_t;

    // Smallest n such that 2**n >= value (value >= 1).
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/xeng_win_sched_ctrl_delay.sv
// Fixed-depth shift register that lines the X-engine controls up with
// buffer read data. Depth must be at least 1.
module xeng_win_sched_ctrl_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the control word one stage per cycle; reset flushes every stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/xeng_win_sched.sv
// Window scheduler: claims buffered integration windows, reads them out in
// antenna-fastest order and drives the X-engine sync/vld/mcnt controls.
module xeng_win_sched
    import xeng_win_sched_pkg::*;
#(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int N_ANTS              = 32,
    parameter int BRAM_LATENCY        = 2,
    parameter int MCNT_WIDTH          = 48,
    localparam int ANT_BITS           = log2_ceil(N_ANTS),
    localparam int AW                 = ANT_BITS + SERIAL_ACC_LEN_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_en_i,
    input  logic                  clr_err_i,
    input  logic                  win_avail_i,
    input  logic [MCNT_WIDTH-1:0] win_mcnt_i,
    output logic                  win_claim_o,
    output logic                  win_done_o,
    output logic                  rd_en_o,
    output logic [AW-1:0]         rd_addr_o,
    output logic                  xeng_sync_o,
    output logic                  xeng_vld_o,
    output logic [MCNT_WIDTH-1:0] xeng_mcnt_o,
    output logic [31:0]           win_count_o,
    output logic                  busy_o,
    output logic                  underrun_o
);

    localparam int            W         = N_ANTS << SERIAL_ACC_LEN_BITS;
    localparam logic [AW-1:0] ADDR_LAST = AW'(W - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam int            CTRL_W    = MCNT_WIDTH + 2;

    sched_state_t          state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [MCNT_WIDTH-1:0] mcnt_q, mcnt_d;
    logic [31:0]           win_count_q, win_count_d;
    logic                  underrun_q, underrun_d;
    logic                  run_en_q;

    logic                  run_rise_s;
    logic                  claim_s;
    logic                  done_s;
    logic                  sync_s;
    logic                  rd_en_s;
    logic [CTRL_W-1:0]     ctrl_in_s;
    logic [CTRL_W-1:0]     ctrl_out_s;

    assign run_rise_s = run_en_i & ~run_en_q;

    // State, read counter, latched mcnt, window counter and error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= {AW{1'b0}};
            mcnt_q      <= {MCNT_WIDTH{1'b0}};
            win_count_q <= 32'd0;
            underrun_q  <= 1'b0;
            run_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mcnt_q      <= mcnt_d;
            win_count_q <= win_count_d;
            underrun_q  <= underrun_d;
            run_en_q    <= run_en_i;
        end
    end

    // Next-state logic; window boundaries either chain into the next window
    // without a gap, stop on disarm, or flag an underrun.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mcnt_d      = mcnt_q;
        win_count_d = win_count_q;
        claim_s     = 1'b0;
        done_s      = 1'b0;
        sync_s      = 1'b0;
        rd_en_s     = 1'b0;

        // A set in the same cycle below overrides this clear.
        if (clr_err_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (run_rise_s && !underrun_q) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!run_en_i) begin
                    state_d = ST_IDLE;
                end else if (win_avail_i) begin
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SYNC: begin
                claim_s = 1'b1;
                sync_s  = 1'b1;
                mcnt_d  = win_mcnt_i;
                addr_d  = {AW{1'b0}};
                state_d = ST_RUN;
            end
            ST_RUN: begin
                rd_en_s = 1'b1;
                if (addr_q == ADDR_LAST) begin
                    done_s      = 1'b1;
                    win_count_d = win_count_q + 32'd1;
                    addr_d      = {AW{1'b0}};
                    if (!run_en_i) begin
                        state_d = ST_IDLE;
                    end else if (win_avail_i) begin
                        claim_s = 1'b1;
                        mcnt_d  = win_mcnt_i;
                        state_d = ST_RUN;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = {AW{1'b0}};
            end
        endcase
    end

    // Controls travel through the same latency as the buffer read so vld
    // coincides with read data.
    assign ctrl_in_s = {sync_s, rd_en_s, mcnt_q};

    xeng_win_sched_ctrl_delay #(
        .DEPTH (BRAM_LATENCY),
        .WIDTH (CTRL_W)
    ) u_ctrl_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ctrl_in_s),
        .q_o   (ctrl_out_s)
    );

    assign xeng_sync_o = ctrl_out_s[CTRL_W-1];
    assign xeng_vld_o  = ctrl_out_s[CTRL_W-2];
    assign xeng_mcnt_o = ctrl_out_s[MCNT_WIDTH-1:0];

    assign win_claim_o = claim_s;
    assign win_done_o  = done_s;
    assign rd_en_o     = rd_en_s;
    assign rd_addr_o   = addr_q;
    assign win_count_o = win_count_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign underrun_o  = underrun_q;

endmodule
